// File: rtl/hamming_transmitter.sv
// hamming_transmitter: Hamming(7,4) encoder that serialises the codeword, position 1 first,
// one bit per BIT_CYCLES-cycle slot with a mid-slot strobe.
module hamming_transmitter #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:4] d_in,
  input  logic       load,
  input  logic [2:0] inj_pos,
  output logic       data_line,
  output logic       strobe,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] MID = CW'(BIT_CYCLES / 2);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state;
  logic [1:4] d_reg;
  logic [2:0] inj_reg;
  logic [2:0] bit_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [6:0] cw;
  logic slot_end, last;
  logic [CW-1:0] cyc_nxt;
  logic [2:0] bit_nxt;
  // cw[i] holds codeword position i+1, so bit_cnt indexes it directly
  always_comb begin
    cw = {d_reg[4], d_reg[3], d_reg[2], d_reg[2] ^ d_reg[3] ^ d_reg[4],
          d_reg[1], d_reg[1] ^ d_reg[3] ^ d_reg[4], d_reg[1] ^ d_reg[2] ^ d_reg[4]};
    cw = inj_reg == 3'd0 ? cw : cw ^ (7'd1 << (inj_reg - 3'd1));
    slot_end = cyc_cnt == LAST;
    last = slot_end && bit_cnt == 3'd6;
    cyc_nxt = slot_end ? '0 : cyc_cnt + CW'(1);
    bit_nxt = slot_end ? bit_cnt + 3'd1 : bit_cnt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      d_reg <= '0;
      inj_reg <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      data_line <= 1'b0;
      strobe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          state <= SEND;
          d_reg <= d_in;
          inj_reg <= inj_pos;
          bit_cnt <= '0;
          cyc_cnt <= '0;
          // position 1 (p1) must already be on the line in the first SEND cycle
          data_line <= d_in[1] ^ d_in[2] ^ d_in[4] ^ (inj_pos == 3'd1);
          busy <= 1'b1;
        end
        SEND: if (last) begin
          state <= DONE;
          data_line <= 1'b0;
          strobe <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cyc_cnt <= cyc_nxt;
          bit_cnt <= bit_nxt;
          data_line <= cw[bit_nxt];
          strobe <= cyc_nxt == MID;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          bit_cnt <= '0;
          cyc_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_transmitter.sv
// tb_hamming_transmitter: directed checks of framing, codewords, error injection and reset abort,
// decoding the received stream with a reference single-error corrector.
module tb_hamming_transmitter;
  logic clk = 1'b0;
  logic rst, load, load2;
  logic [1:4] d_in;
  logic [2:0] inj_pos;
  logic data_line, strobe, busy, done;
  logic data_line2, strobe2, busy2, done2;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [6:0] CW_TAB [16] = '{
    7'b0000000, 7'b1101001, 7'b0101010, 7'b1000011,
    7'b1001100, 7'b0100101, 7'b1100110, 7'b0001111,
    7'b1110000, 7'b0011001, 7'b1011010, 7'b0110011,
    7'b0111100, 7'b1010101, 7'b0010110, 7'b1111111};
  always #5 clk = ~clk;
  hamming_transmitter #(.BIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .d_in(d_in), .load(load), .inj_pos(inj_pos),
    .data_line(data_line), .strobe(strobe), .busy(busy), .done(done));
  hamming_transmitter #(.BIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .d_in(d_in), .load(load2), .inj_pos(inj_pos),
    .data_line(data_line2), .strobe(strobe2), .busy(busy2), .done(done2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // receiver-side model: r[6] is position 1
  function automatic logic [3:0] correct(input logic [6:0] r);
    logic [2:0] s;
    s = {r[3] ^ r[2] ^ r[1] ^ r[0], r[5] ^ r[4] ^ r[1] ^ r[0], r[6] ^ r[4] ^ r[2] ^ r[0]};
    if (s != 3'd0) r = r ^ (7'h40 >> (s - 3'd1));
    return {r[4], r[2], r[1], r[0]};
  endfunction
  task automatic watch(input int bc, input logic [6:0] exp_cw, input logic [3:0] exp_d, input string tag);
    logic [6:0] rx;
    logic [31:0] smask, dmask, exp_s;
    logic dl, sb, bz, dn;
    int busy_n, hold_err, n;
    rx = '0; smask = '0; dmask = '0; exp_s = '0; busy_n = 0; hold_err = 0; n = 7 * bc;
    for (int i = 0; i < 7; i++) exp_s[i * bc + bc / 2] = 1'b1;
    for (int k = 0; k < n + 2; k++) begin
      @(negedge clk);
      dl = bc == 4 ? data_line : data_line2;
      sb = bc == 4 ? strobe : strobe2;
      bz = bc == 4 ? busy : busy2;
      dn = bc == 4 ? done : done2;
      if (bz) busy_n++;
      if (sb) begin
        smask[k] = 1'b1;
        rx = {rx[5:0], dl};
      end
      if (dn) dmask[k] = 1'b1;
      if (k < n) begin
        if (dl !== exp_cw[6 - k / bc]) hold_err++;
      end else if (dl !== 1'b0) hold_err++;
      if (k == n + 1) check({tag, " idle"}, {28'd0, dl, sb, bz, dn}, 32'd0);
    end
    check({tag, " codeword"}, {25'd0, rx}, {25'd0, exp_cw});
    check({tag, " decoded"}, {28'd0, correct(rx)}, {28'd0, exp_d});
    check({tag, " busy cycles"}, busy_n, n);
    check({tag, " strobe timing"}, smask, exp_s);
    check({tag, " done timing"}, dmask, 32'd1 << n);
    check({tag, " line hold"}, hold_err, 0);
  endtask
  task automatic frame(input int bc, input logic [3:0] d, input logic [2:0] inj, input logic [6:0] exp_cw, input string tag);
    @(negedge clk);
    d_in = d;
    inj_pos = inj;
    if (bc == 4) load = 1'b1;
    else load2 = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    load2 = 1'b0;
    watch(bc, exp_cw, d, tag);
  endtask
  initial begin
    int spurious;
    rst = 1'b0; load = 1'b0; load2 = 1'b0; d_in = '0; inj_pos = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", {24'd0, data_line, strobe, busy, done, data_line2, strobe2, busy2, done2}, 32'd0);
    rst = 1'b1;
    frame(4, 4'b1011, 3'd0, 7'b0110011, "basic1011");
    for (int v = 0; v < 16; v++) frame(4, 4'(v), 3'd0, CW_TAB[v], $sformatf("val%0d", v));
    for (int p = 1; p <= 7; p++)
      frame(4, 4'b1011, 3'(p), 7'b0110011 ^ (7'h40 >> (p - 1)), $sformatf("inj%0d", p));
    // load held high; d_in changes after acceptance
    @(negedge clk);
    d_in = 4'b1011; inj_pos = 3'd0; load = 1'b1;
    @(posedge clk);
    #1 d_in = 4'b0000;
    watch(4, 7'b0110011, 4'b1011, "held1");
    @(posedge clk);
    #1 load = 1'b0;
    watch(4, 7'b0000000, 4'b0000, "held2");
    // abort during slot 4
    @(negedge clk);
    d_in = 4'b1011; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-abort busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b0;
    #1 check("async reset", {28'd0, data_line, strobe, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    spurious = 0;
    repeat (35) begin
      @(negedge clk);
      if (strobe || done || busy) spurious++;
    end
    check("post-abort quiet", spurious, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; load = 1'b1; d_in = 4'b1011; inj_pos = 3'd0;
    @(posedge clk);
    #1 load = 1'b0;
    watch(4, 7'b0110011, 4'b1011, "after-reset");
    frame(2, 4'b1011, 3'd0, 7'b0110011, "bc2 1011");
    frame(2, 4'b1111, 3'd0, 7'b1111111, "bc2 1111");
    frame(2, 4'b1011, 3'd5, 7'b0110111, "bc2 inj5");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
